// File: rtl/gate_resp_checker.sv
// Response checker for a gate under test: compares each valid response against a
// selected reference function, counts vectors/errors and gives a registered verdict.
module gate_resp_checker #(
  parameter int WIDTH     = 1,
  parameter int N_VECTORS = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       func_sel,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] stim,
  input  logic [WIDTH-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_fail_vld,
  output logic [CNT_W-1:0] first_fail_idx
);

  // Handshake: a stim/resp pair is consumed on any rising edge where in_valid is
  // high, the checker is in RUN and start is low; there is no back-pressure.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_VECTORS - 1);
  localparam logic [CNT_W-1:0] SAT  = '1;

  state_t state, next_state;

  logic [1:0]       func_q, func_d;
  logic [WIDTH-1:0] expected;
  logic             sample, miss;
  logic             busy_d, done_d, pass_d, mismatch_d, ffv_d;
  logic [CNT_W-1:0] vec_d, err_d, idx_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN: begin
        if (start)                                 next_state = RUN;
        else if (in_valid && (vec_cnt == LAST))    next_state = DONE;
      end
      DONE: if (start) next_state = RUN;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    expected = '0;
    case (func_q)
      2'b00:   expected = ~stim;
      2'b01:   expected = stim;
      2'b10:   expected = '0;
      default: expected = '1;
    endcase
  end

  // A sample arriving with start is dropped: the run it would belong to is being cleared.
  assign sample = (state == RUN) && in_valid && !start;
  assign miss   = sample && (resp != expected);

  // Output / datapath next-value logic
  always_comb begin
    func_d     = func_q;
    vec_d      = vec_cnt;
    err_d      = err_cnt;
    ffv_d      = first_fail_vld;
    idx_d      = first_fail_idx;
    pass_d     = pass;
    mismatch_d = 1'b0;
    busy_d     = (next_state == RUN);
    done_d     = (next_state == DONE);
    if (start) begin
      func_d = func_sel;
      vec_d  = '0;
      err_d  = '0;
      ffv_d  = 1'b0;
      idx_d  = '0;
      pass_d = 1'b0;
    end else if (sample) begin
      vec_d = vec_cnt + 1'b1;
      if (miss) begin
        mismatch_d = 1'b1;
        if (err_cnt != SAT) err_d = err_cnt + 1'b1;
        if (!first_fail_vld) begin
          ffv_d = 1'b1;
          idx_d = vec_cnt;
        end
      end
      if (next_state == DONE) pass_d = (err_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_q         <= 2'b00;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch       <= 1'b0;
      vec_cnt        <= '0;
      err_cnt        <= '0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
    end else begin
      func_q         <= func_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      mismatch       <= mismatch_d;
      vec_cnt        <= vec_d;
      err_cnt        <= err_d;
      first_fail_vld <= ffv_d;
      first_fail_idx <= idx_d;
    end
  end

endmodule

// File: tb/tb_gate_resp_checker.sv
// Bench for gate_resp_checker: directed runs against a run-level reference model,
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_gate_resp_checker;

  localparam int WIDTH = 4;
  localparam int NV    = 4;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start = 1'b0;
  logic [1:0]    func_sel = 2'b00;
  logic          in_valid = 1'b0;
  logic [WIDTH-1:0] stim = '0;
  logic [WIDTH-1:0] resp = '0;
  logic          busy, done, pass, mismatch, first_fail_vld;
  logic [CW-1:0] vec_cnt, err_cnt, first_fail_idx;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit cmp_en = 1'b0;

  gate_resp_checker #(.WIDTH(WIDTH), .N_VECTORS(NV), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func_sel(func_sel),
    .in_valid(in_valid), .stim(stim), .resp(resp), .busy(busy), .done(done),
    .pass(pass), .mismatch(mismatch), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .first_fail_vld(first_fail_vld), .first_fail_idx(first_fail_idx)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: a run is "active" between start and the N-th accepted sample.
  function automatic logic [WIDTH-1:0] ref_fn(input logic [1:0] f, input logic [WIDTH-1:0] s);
    case (f)
      2'b00:   return ~s;
      2'b01:   return s;
      2'b10:   return {WIDTH{1'b0}};
      default: return {WIDTH{1'b1}};
    endcase
  endfunction

  logic          m_active = 1'b0, m_done = 1'b0, m_pass = 1'b0, m_mis = 1'b0, m_ffv = 1'b0;
  logic [1:0]    m_func = 2'b00;
  int            m_vec = 0, m_err = 0, m_idx = 0;
  logic          m_bad;

  assign m_bad = (resp != ref_fn(m_func, stim));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_done <= 1'b0; m_pass <= 1'b0; m_mis <= 1'b0;
      m_ffv <= 1'b0; m_func <= 2'b00; m_vec <= 0; m_err <= 0; m_idx <= 0;
    end else begin
      m_mis <= 1'b0;
      if (start) begin
        m_active <= 1'b1; m_done <= 1'b0; m_pass <= 1'b0; m_ffv <= 1'b0;
        m_func <= func_sel; m_vec <= 0; m_err <= 0; m_idx <= 0;
      end else if (m_active && in_valid) begin
        m_vec <= m_vec + 1;
        if (m_bad) begin
          m_mis <= 1'b1;
          m_err <= (m_err == (1 << CW) - 1) ? m_err : m_err + 1;
          if (!m_ffv) begin
            m_ffv <= 1'b1;
            m_idx <= m_vec;
          end
        end
        if (m_vec + 1 == NV) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
          m_pass   <= (m_err + int'(m_bad)) == 0;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", int'(busy), int'(m_active));
      check("done", int'(done), int'(m_done));
      check("mismatch", int'(mismatch), int'(m_mis));
      check("vec_cnt", int'(vec_cnt), m_vec);
      check("err_cnt", int'(err_cnt), m_err);
      check("first_fail_vld", int'(first_fail_vld), int'(m_ffv));
      if (m_ffv) check("first_fail_idx", int'(first_fail_idx), m_idx);
      if (m_done) check("pass", int'(pass), int'(m_pass));
      if (mismatch) pulses++;
    end
  end

  // Driver tasks
  task automatic drive(input logic st, input logic [1:0] fs, input logic v,
                       input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] r);
    @(negedge clk);
    start = st; func_sel = fs; in_valid = v; stim = s; resp = r;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, func_sel, 1'b0, '0, '0);
  endtask

  task automatic pin(input string tag, input int d, input int p, input int e,
                     input int fv, input int fi, input int v);
    #1;
    check({tag, "_done"}, int'(done), d);
    check({tag, "_pass"}, int'(pass), p);
    check({tag, "_err"}, int'(err_cnt), e);
    check({tag, "_ffv"}, int'(first_fail_vld), fv);
    check({tag, "_idx"}, int'(first_fail_idx), fi);
    check({tag, "_vec"}, int'(vec_cnt), v);
  endtask

  initial begin
    rst_n = 1'b0;
    #12;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_vec", int'(vec_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // 1: NOT, correct responses
    pulses = 0;
    drive(1, 2'b00, 0, 4'h0, 4'h0);
    drive(0, 2'b00, 1, 4'h0, 4'hF);
    drive(0, 2'b00, 1, 4'hF, 4'h0);
    drive(0, 2'b00, 1, 4'h0, 4'hF);
    drive(0, 2'b00, 1, 4'hF, 4'h0);
    idle(1);
    pin("t1", 1, 1, 0, 0, 0, 4);
    check("t1_pulses", pulses, 0);
    check("t1_busy", int'(busy), 0);

    // 2: NOT, faulty gate on samples 1 and 2
    pulses = 0;
    drive(1, 2'b00, 0, 4'h0, 4'h0);
    drive(0, 2'b00, 1, 4'h0, 4'hF);
    drive(0, 2'b00, 1, 4'hF, 4'hF);
    drive(0, 2'b00, 1, 4'h0, 4'h0);
    drive(0, 2'b00, 1, 4'hF, 4'h0);
    idle(1);
    pin("t2", 1, 0, 2, 1, 1, 4);
    check("t2_pulses", pulses, 2);

    // 3: BUF with idle gaps
    drive(1, 2'b01, 0, 4'h0, 4'h0);
    drive(0, 2'b01, 1, 4'hA, 4'hA);
    idle(3);
    #1 check("t3_gap_vec", int'(vec_cnt), 1);
    drive(0, 2'b01, 1, 4'h5, 4'h5);
    drive(0, 2'b01, 1, 4'hF, 4'hE);
    drive(0, 2'b01, 1, 4'h0, 4'h0);
    idle(1);
    pin("t3", 1, 0, 1, 1, 2, 4);

    // 4: func_sel changes mid-run, captured NOT still applies
    drive(1, 2'b00, 0, 4'h0, 4'h0);
    drive(0, 2'b00, 1, 4'h3, 4'hC);
    drive(0, 2'b01, 1, 4'h9, 4'h6);
    drive(0, 2'b01, 1, 4'h0, 4'hF);
    drive(0, 2'b01, 1, 4'hF, 4'h0);
    idle(1);
    pin("t4", 1, 1, 0, 0, 0, 4);

    // 5: restart during RUN with a coincident sample
    drive(1, 2'b00, 0, 4'h0, 4'h0);
    drive(0, 2'b00, 1, 4'h0, 4'h0);
    idle(1);
    #1 check("t5_err_before", int'(err_cnt), 1);
    drive(1, 2'b00, 1, 4'h0, 4'h0);
    idle(1);
    pin("t5_clr", 0, 0, 0, 0, 0, 0);
    check("t5_busy", int'(busy), 1);
    for (int i = 0; i < NV; i++) drive(0, 2'b00, 1, 4'(i), ~4'(i));
    idle(1);
    pin("t5", 1, 1, 0, 0, 0, 4);

    // 6: asynchronous reset mid-run, then DONE ignores extra samples
    drive(1, 2'b10, 0, 4'h0, 4'h0);
    drive(0, 2'b10, 1, 4'h7, 4'h1);
    drive(0, 2'b10, 1, 4'h7, 4'h0);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    pin("t6_rst", 0, 0, 0, 0, 0, 0);
    check("t6_busy", int'(busy), 0);
    check("t6_mismatch", int'(mismatch), 0);
    check("t6_state", int'(dut.state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 2'b11, 0, 4'h0, 4'h0);
    for (int i = 0; i < NV; i++) drive(0, 2'b11, 1, 4'(i), 4'hF);
    for (int i = 0; i < 3; i++) drive(0, 2'b11, 1, 4'h0, 4'h0);
    idle(1);
    pin("t6_done", 1, 1, 0, 0, 0, 4);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
